// File: rtl/pipe_ctrl_if.sv
// Stall/flush handshake bundle between the pipeline stages and pipe_ctrl.
// master = pipeline side (requests, exception info); slave = controller.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        exc_busy;
  logic        stall_timeout;
  logic [31:0] stall_cnt;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, exc_busy, stall_timeout, stall_cnt
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, exc_busy, stall_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall arbitration, exception accept->flush
// sequencing, stall watchdog and debug stall-cycle counter.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned WD_W       = 10,
  parameter int unsigned WD_LIMIT   = 1023
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [31:0]     ExcEret = 32'h0000_000e;
  localparam logic [WD_W-1:0] WdLimit = WD_W'(WD_LIMIT);

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StFlush = 2'b01
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [5:0]      w_stall;
  logic            w_flush;
  logic            w_busy;
  logic            w_accept;
  logic [31:0]     r_new_pc;
  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_nxt;
  logic            r_timeout;
  logic [31:0]     r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = StRun;
    w_stall     = 6'b000000;
    w_flush     = 1'b0;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      StRun: begin
        // An exception waits out a MEM stall so the faulting access settles first.
        if ((bus.excepttype_i != 32'h0) && !bus.stallreq_mem) begin
          w_accept    = 1'b1;
          w_stall     = 6'b011111;
          w_busy      = 1'b1;
          w_state_nxt = StFlush;
        end else if (bus.stallreq_mem) begin
          w_stall = 6'b011111;
        end else if (bus.stallreq_ex) begin
          w_stall = 6'b001111;
        end else if (bus.stallreq_id || bus.stallreq_if) begin
          w_stall = 6'b000111;
        end
      end
      StFlush: begin
        w_flush = 1'b1;
        w_busy  = 1'b1;
      end
      default: w_state_nxt = StRun;
    endcase
  end

  assign bus.stall         = rst ? w_stall : 6'b000000;
  assign bus.flush         = rst & w_flush;
  assign bus.exc_busy      = rst & w_busy;
  assign bus.new_pc        = r_new_pc;
  assign bus.stall_timeout = r_timeout;
  assign bus.stall_cnt     = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_new_pc <= 32'h0;
    end else if (w_accept) begin
      r_new_pc <= (bus.excepttype_i == ExcEret) ? bus.cp0_epc_i : EXC_VECTOR;
    end
  end

  always_comb begin
    if (!bus.stall[0]) begin
      w_wd_nxt = '0;
    end else if (r_wd_cnt == WdLimit) begin
      w_wd_nxt = r_wd_cnt;
    end else begin
      w_wd_nxt = r_wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= 32'h0;
    end else begin
      r_wd_cnt  <= w_wd_nxt;
      r_timeout <= r_timeout | (w_wd_nxt == WdLimit);
      if (bus.stall[0]) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: scoreboard of per-cycle expected outputs.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR(32'h0000_0020),
    .WD_W      (10),
    .WD_LIMIT  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
  } exp_t;

  // req = {mem, ex, id, if}
  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] exc;
    logic [31:0] epc;
  } stim_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned exp_cnt  = 0;
  logic        exp_to   = 1'b0;

  task automatic drive(input stim_t s, input exp_t e);
    {bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if} = s.req;
    bus.excepttype_i = s.exc;
    bus.cp0_epc_i    = s.epc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e, obs;
    #2 rst = 1'b0;
    drive('{4'hf, 32'h8, 32'h0}, '{6'h00, 1'b0, 32'h0, 1'b0});
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", obs, e);
    end
    checks++;
    if (bus.stall_cnt !== 32'h0 || bus.stall_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_counters got cnt=%h to=%b exp cnt=0 to=0",
               bus.stall_cnt, bus.stall_timeout);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive('{4'hf, 32'h0, 32'h0}, '{6'h1f, 1'b0, 32'h0, 1'b0});
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs, e);
    end
    if (e.stall[0]) exp_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    stim_t st [8] = '{'{4'b0010, 32'h0, 32'h0}, '{4'b0110, 32'h0, 32'h0},
                      '{4'b1110, 32'h0, 32'h0}, '{4'b0000, 32'h0, 32'h0},
                      '{4'b0001, 32'h0, 32'h0}, '{4'b0001, 32'h0, 32'h0},
                      '{4'b0001, 32'h0, 32'h0}, '{4'b0000, 32'h0, 32'h0}};
    logic [5:0] es [8] = '{6'h07, 6'h0f, 6'h1f, 6'h00, 6'h07, 6'h07, 6'h07, 6'h00};
    exp_t e, obs;
    for (int i = 0; i < 8; i++) begin
      drive(st[i], '{es[i], 1'b0, 32'h0, 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL priority[%0d] got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (bus.stall_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL priority_cnt[%0d] got=%0d exp=%0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall[0]) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_syscall();
    stim_t st [3] = '{'{4'h0, 32'h8, 32'h0}, '{4'h0, 32'h0, 32'h0}, '{4'h0, 32'h0, 32'h0}};
    exp_t  ex [3] = '{'{6'h1f, 1'b0, 32'h0, 1'b1}, '{6'h00, 1'b1, 32'h20, 1'b1},
                      '{6'h00, 1'b0, 32'h20, 1'b0}};
    exp_t e, obs;
    for (int i = 0; i < 3; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL syscall[%0d] got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (bus.stall_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL syscall_cnt[%0d] got=%0d exp=%0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall[0]) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_eret_mem_stall();
    stim_t st [6] = '{'{4'h8, 32'he, 32'h1234}, '{4'h8, 32'he, 32'h1234},
                      '{4'h8, 32'he, 32'h1234}, '{4'h0, 32'he, 32'h1234},
                      '{4'h8, 32'he, 32'h1234}, '{4'h0, 32'h0, 32'h1234}};
    exp_t  ex [6] = '{'{6'h1f, 1'b0, 32'h20, 1'b0}, '{6'h1f, 1'b0, 32'h20, 1'b0},
                      '{6'h1f, 1'b0, 32'h20, 1'b0}, '{6'h1f, 1'b0, 32'h20, 1'b1},
                      '{6'h00, 1'b1, 32'h1234, 1'b1}, '{6'h00, 1'b0, 32'h1234, 1'b0}};
    exp_t e, obs;
    for (int i = 0; i < 6; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL eret[%0d] got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (bus.stall_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL eret_cnt[%0d] got=%0d exp=%0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall[0]) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st [5] = '{'{4'h4, 32'h8, 32'h0}, '{4'h4, 32'h8, 32'h0}, '{4'h0, 32'h8, 32'h0},
                      '{4'h0, 32'h0, 32'h0}, '{4'h0, 32'h0, 32'h0}};
    exp_t  ex [5] = '{'{6'h1f, 1'b0, 32'h1234, 1'b1}, '{6'h00, 1'b1, 32'h20, 1'b1},
                      '{6'h1f, 1'b0, 32'h20, 1'b1}, '{6'h00, 1'b1, 32'h20, 1'b1},
                      '{6'h00, 1'b0, 32'h20, 1'b0}};
    exp_t e, obs;
    for (int i = 0; i < 5; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (bus.stall_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL b2b_cnt[%0d] got=%0d exp=%0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall[0]) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    // 7 stalls, gap, 7 stalls (proves the clear), gap, 8 stalls (trips), 2 idle.
    logic pat[$];
    int   run = 0;
    exp_t e, obs;
    repeat (7) pat.push_back(1'b1);
    pat.push_back(1'b0);
    repeat (7) pat.push_back(1'b1);
    pat.push_back(1'b0);
    repeat (8) pat.push_back(1'b1);
    repeat (2) pat.push_back(1'b0);
    for (int i = 0; i < pat.size(); i++) begin
      if (pat[i]) drive('{4'h4, 32'h0, 32'h0}, '{6'h0f, 1'b0, 32'h20, 1'b0});
      else        drive('{4'h0, 32'h0, 32'h0}, '{6'h00, 1'b0, 32'h20, 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL watchdog[%0d] got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (bus.stall_timeout !== exp_to) begin
        failures++;
        $display("FAIL watchdog_to[%0d] got=%b exp=%b", i, bus.stall_timeout, exp_to);
      end
      checks++;
      if (bus.stall_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL watchdog_cnt[%0d] got=%0d exp=%0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall[0]) exp_cnt++;
      run = pat[i] ? run + 1 : 0;
      if (run == 8) exp_to = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    exp_t e, obs;
    drive('{4'h0, 32'h8, 32'h0}, '{6'h1f, 1'b0, 32'h20, 1'b1});
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL midflush_accept got=%h exp=%h", obs, e);
    end
    @(posedge clk); #1;
    drive('{4'h0, 32'h0, 32'h0}, '{6'h00, 1'b1, 32'h20, 1'b1});
    e = sb.pop_front();
    obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL midflush_flush got=%h exp=%h", obs, e);
    end
    #1 rst = 1'b0;
    exp_cnt = 0;
    exp_to  = 1'b0;
    drive('{4'hf, 32'h8, 32'h0}, '{6'h00, 1'b0, 32'h0, 1'b0});
    #1;
    e = sb.pop_front();
    obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL midflush_reset got=%h exp=%h", obs, e);
    end
    checks++;
    if (bus.stall_cnt !== exp_cnt || bus.stall_timeout !== exp_to) begin
      failures++;
      $display("FAIL midflush_counters got cnt=%0d to=%b exp cnt=0 to=0",
               bus.stall_cnt, bus.stall_timeout);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive('{4'h0, 32'h0, 32'h0}, '{6'h00, 1'b0, 32'h0, 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      obs = {bus.stall, bus.flush, bus.new_pc, bus.exc_busy};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL midflush_after[%0d] got=%h exp=%h", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_syscall();
    test_eret_mem_stall();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
